// File: rtl/axi_slice_dc_slave_drain_ctrl.sv
// Slave-side drain controller for the dual-clock AXI slice: counts in-flight bursts, gates new
// AW/AR and W on isolation requests, and acknowledges once the crossing is quiescent.
module axi_slice_dc_slave_drain_ctrl #(
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 64,
    parameter int unsigned AXI_USER_WIDTH  = 6,
    parameter int unsigned AXI_ID_WIDTH    = 6,
    parameter int unsigned MAX_OUTSTANDING = 16,
    // Packed payloads: AW/AR = {id, addr, len, size, burst, lock, cache, prot, qos, region, user},
    // W = {data, strb, user}, B = {id, resp, user}, R = {id, data, resp, user}; last is separate.
    localparam int unsigned AX_W = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 29 + AXI_USER_WIDTH,
    localparam int unsigned W_W  = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + AXI_USER_WIDTH,
    localparam int unsigned B_W  = AXI_ID_WIDTH + 2 + AXI_USER_WIDTH,
    localparam int unsigned R_W  = AXI_ID_WIDTH + AXI_DATA_WIDTH + 2 + AXI_USER_WIDTH
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            isolate_req_i,
    output logic            isolate_ack_o,
    output logic            busy_o,
    // AW channel
    input  logic [AX_W-1:0] s_aw_payload_i,
    input  logic            s_aw_valid_i,
    output logic            s_aw_ready_o,
    output logic [AX_W-1:0] m_aw_payload_o,
    output logic            m_aw_valid_o,
    input  logic            m_aw_ready_i,
    // AR channel
    input  logic [AX_W-1:0] s_ar_payload_i,
    input  logic            s_ar_valid_i,
    output logic            s_ar_ready_o,
    output logic [AX_W-1:0] m_ar_payload_o,
    output logic            m_ar_valid_o,
    input  logic            m_ar_ready_i,
    // W channel
    input  logic [W_W-1:0]  s_w_payload_i,
    input  logic            s_w_last_i,
    input  logic            s_w_valid_i,
    output logic            s_w_ready_o,
    output logic [W_W-1:0]  m_w_payload_o,
    output logic            m_w_last_o,
    output logic            m_w_valid_o,
    input  logic            m_w_ready_i,
    // B channel
    input  logic [B_W-1:0]  m_b_payload_i,
    input  logic            m_b_valid_i,
    output logic            m_b_ready_o,
    output logic [B_W-1:0]  s_b_payload_o,
    output logic            s_b_valid_o,
    input  logic            s_b_ready_i,
    // R channel
    input  logic [R_W-1:0]  m_r_payload_i,
    input  logic            m_r_last_i,
    input  logic            m_r_valid_i,
    output logic            m_r_ready_o,
    output logic [R_W-1:0]  s_r_payload_o,
    output logic            s_r_last_o,
    output logic            s_r_valid_o,
    input  logic            s_r_ready_i
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_ISOLATED = 2'd2
    } state_e;

    state_e           state_q;
    logic             isolate_ack_q;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] w_owed_q, w_owed_d;
    logic             aw_hold_q, aw_hold_d;
    logic             ar_hold_q, ar_hold_d;

    logic aw_gate_s, ar_gate_s, w_gate_s;
    logic aw_hs_s, ar_hs_s, w_done_s, b_hs_s, r_done_s;
    logic drained_s;

    // A decrement at zero is a protocol error upstream; the count holds rather than wrapping.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        logic [CNT_W-1:0] res;
        res = cnt;
        case ({inc, dec})
            2'b10:   res = cnt + CNT_W'(1);
            2'b01:   res = (cnt == '0) ? cnt : cnt - CNT_W'(1);
            default: res = cnt;
        endcase
        return res;
    endfunction

    assign m_aw_payload_o = s_aw_payload_i;
    assign m_ar_payload_o = s_ar_payload_i;
    assign m_w_payload_o  = s_w_payload_i;
    assign m_w_last_o     = s_w_last_i;
    assign s_b_payload_o  = m_b_payload_i;
    assign s_r_payload_o  = m_r_payload_i;
    assign s_r_last_o     = m_r_last_i;
    assign isolate_ack_o  = isolate_ack_q;
    assign busy_o         = (wr_cnt_q != '0) || (rd_cnt_q != '0) || (w_owed_q != '0);

    // Handshake gating; a held address keeps its gate open so it is never withdrawn.
    always_comb begin
        aw_gate_s = ((state_q == ST_RUN) && (wr_cnt_q < MAX_CNT) && (w_owed_q < MAX_CNT))
                    || aw_hold_q;
        ar_gate_s = ((state_q == ST_RUN) && (rd_cnt_q < MAX_CNT)) || ar_hold_q;

        m_aw_valid_o = s_aw_valid_i & aw_gate_s;
        s_aw_ready_o = m_aw_ready_i & aw_gate_s;
        m_ar_valid_o = s_ar_valid_i & ar_gate_s;
        s_ar_ready_o = m_ar_ready_i & ar_gate_s;
        aw_hs_s      = m_aw_valid_o & m_aw_ready_i;
        ar_hs_s      = m_ar_valid_o & m_ar_ready_i;

        // Write data waits for its address, as an AXI slave is allowed to.
        w_gate_s     = (w_owed_q != '0) || aw_hs_s;
        m_w_valid_o  = s_w_valid_i & w_gate_s;
        s_w_ready_o  = m_w_ready_i & w_gate_s;
        w_done_s     = m_w_valid_o & m_w_ready_i & s_w_last_i;

        s_b_valid_o  = m_b_valid_i;
        m_b_ready_o  = s_b_ready_i;
        s_r_valid_o  = m_r_valid_i;
        m_r_ready_o  = s_r_ready_i;
        b_hs_s       = m_b_valid_i & s_b_ready_i;
        r_done_s     = m_r_valid_i & s_r_ready_i & m_r_last_i;

        wr_cnt_d = cnt_next(wr_cnt_q, aw_hs_s, b_hs_s);
        rd_cnt_d = cnt_next(rd_cnt_q, ar_hs_s, r_done_s);
        w_owed_d = cnt_next(w_owed_q, aw_hs_s, w_done_s);

        if (aw_hs_s) begin
            aw_hold_d = 1'b0;
        end else if (m_aw_valid_o) begin
            aw_hold_d = 1'b1;
        end else begin
            aw_hold_d = aw_hold_q;
        end
        if (ar_hs_s) begin
            ar_hold_d = 1'b0;
        end else if (m_ar_valid_o) begin
            ar_hold_d = 1'b1;
        end else begin
            ar_hold_d = ar_hold_q;
        end

        drained_s = (wr_cnt_q == '0) && (rd_cnt_q == '0) && (w_owed_q == '0)
                    && !aw_hold_q && !ar_hold_q && !aw_hs_s && !ar_hs_s;
    end

    // Outstanding counters and address-hold flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            w_owed_q  <= '0;
            aw_hold_q <= 1'b0;
            ar_hold_q <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            w_owed_q  <= w_owed_d;
            aw_hold_q <= aw_hold_d;
            ar_hold_q <= ar_hold_d;
        end
    end

    // Isolation FSM; the acknowledge is registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_RUN;
            isolate_ack_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (isolate_req_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!isolate_req_i) begin
                        state_q <= ST_RUN;
                    end else if (drained_s) begin
                        state_q       <= ST_ISOLATED;
                        isolate_ack_q <= 1'b1;
                    end
                end
                ST_ISOLATED: begin
                    if (!isolate_req_i) begin
                        state_q       <= ST_RUN;
                        isolate_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ST_RUN;
                    isolate_ack_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slice_dc_slave_drain_ctrl.sv
// Randomized bench for axi_slice_dc_slave_drain_ctrl: a transaction-level reference model predicts
// gating and isolation; a monitor checks forwarded payloads against a scoreboard queue.
module tb_axi_slice_dc_slave_drain_ctrl;

    localparam int AX_W = 6 + 32 + 29 + 6;
    localparam int W_W  = 64 + 8 + 6;
    localparam int B_W  = 6 + 2 + 6;
    localparam int R_W  = 6 + 64 + 2 + 6;
    localparam int MAXO = 16;

    logic clk = 1'b0;
    logic rst_n, isolate_req_i, isolate_ack_o, busy_o;
    logic [AX_W-1:0] s_aw_payload_i, m_aw_payload_o, s_ar_payload_i, m_ar_payload_o;
    logic s_aw_valid_i, s_aw_ready_o, m_aw_valid_o, m_aw_ready_i;
    logic s_ar_valid_i, s_ar_ready_o, m_ar_valid_o, m_ar_ready_i;
    logic [W_W-1:0] s_w_payload_i, m_w_payload_o;
    logic s_w_last_i, s_w_valid_i, s_w_ready_o, m_w_last_o, m_w_valid_o, m_w_ready_i;
    logic [B_W-1:0] m_b_payload_i, s_b_payload_o;
    logic m_b_valid_i, m_b_ready_o, s_b_valid_o, s_b_ready_i;
    logic [R_W-1:0] m_r_payload_i, s_r_payload_o;
    logic m_r_last_i, m_r_valid_i, m_r_ready_o, s_r_last_o, s_r_valid_o, s_r_ready_i;

    always #5 clk = ~clk;

    axi_slice_dc_slave_drain_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .isolate_req_i(isolate_req_i),
        .isolate_ack_o(isolate_ack_o), .busy_o(busy_o),
        .s_aw_payload_i(s_aw_payload_i), .s_aw_valid_i(s_aw_valid_i), .s_aw_ready_o(s_aw_ready_o),
        .m_aw_payload_o(m_aw_payload_o), .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i),
        .s_ar_payload_i(s_ar_payload_i), .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o),
        .m_ar_payload_o(m_ar_payload_o), .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i),
        .s_w_payload_i(s_w_payload_i), .s_w_last_i(s_w_last_i), .s_w_valid_i(s_w_valid_i),
        .s_w_ready_o(s_w_ready_o), .m_w_payload_o(m_w_payload_o), .m_w_last_o(m_w_last_o),
        .m_w_valid_o(m_w_valid_o), .m_w_ready_i(m_w_ready_i),
        .m_b_payload_i(m_b_payload_i), .m_b_valid_i(m_b_valid_i), .m_b_ready_o(m_b_ready_o),
        .s_b_payload_o(s_b_payload_o), .s_b_valid_o(s_b_valid_o), .s_b_ready_i(s_b_ready_i),
        .m_r_payload_i(m_r_payload_i), .m_r_last_i(m_r_last_i), .m_r_valid_i(m_r_valid_i),
        .m_r_ready_o(m_r_ready_o), .s_r_payload_o(s_r_payload_o), .s_r_last_o(s_r_last_o),
        .s_r_valid_o(s_r_valid_o), .s_r_ready_i(s_r_ready_i)
    );

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: payloads presented on one side, expected to emerge on the other in order.
    logic [AX_W-1:0] aw_q[$];
    logic [AX_W-1:0] ar_q[$];
    logic [W_W:0]    w_q[$];
    logic [B_W-1:0]  b_q[$];
    logic [R_W:0]    r_q[$];

    // Reference model: outstanding bursts as plain integers, mode 0=run 1=drain 2=isolated.
    int wr_out, rd_out, w_owe, mode;
    bit aw_shown, ar_shown;

    int p_aw, p_ar, p_w, p_rsp, p_mready, p_sready;
    bit req_want;
    bit aw_done, ar_done, w_done, b_done, r_done;

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic underflow(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s t=%0t got=transfer want=none (nothing pending)", nm, $time);
    endtask

    task automatic model_reset();
        wr_out = 0; rd_out = 0; w_owe = 0; mode = 0;
        aw_shown = 1'b0; ar_shown = 1'b0;
    endtask

    task automatic step();
        logic [127:0] r;
        bit aw_ok, ar_ok, w_ok, aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs, quiet;
        logic [9:0] exp_gate, act_gate;
        @(negedge clk);
        if (aw_done) s_aw_valid_i = 1'b0;
        if (ar_done) s_ar_valid_i = 1'b0;
        if (w_done)  s_w_valid_i  = 1'b0;
        if (b_done)  m_b_valid_i  = 1'b0;
        if (r_done)  m_r_valid_i  = 1'b0;
        isolate_req_i = req_want;
        if (!s_aw_valid_i && $urandom_range(99) < p_aw) begin
            r = rnd128(); s_aw_payload_i = r[AX_W-1:0]; s_aw_valid_i = 1'b1;
            aw_q.push_back(s_aw_payload_i);
        end
        if (!s_ar_valid_i && $urandom_range(99) < p_ar) begin
            r = rnd128(); s_ar_payload_i = r[AX_W-1:0]; s_ar_valid_i = 1'b1;
            ar_q.push_back(s_ar_payload_i);
        end
        if (!s_w_valid_i && $urandom_range(99) < p_w) begin
            r = rnd128(); s_w_payload_i = r[W_W-1:0]; s_w_last_i = ($urandom_range(3) == 0);
            s_w_valid_i = 1'b1;
            w_q.push_back({s_w_last_i, s_w_payload_i});
        end
        if (!m_b_valid_i && wr_out > 0 && $urandom_range(99) < p_rsp) begin
            r = rnd128(); m_b_payload_i = r[B_W-1:0]; m_b_valid_i = 1'b1;
            b_q.push_back(m_b_payload_i);
        end
        if (!m_r_valid_i && rd_out > 0 && $urandom_range(99) < p_rsp) begin
            r = rnd128(); m_r_payload_i = r[R_W-1:0]; m_r_last_i = ($urandom_range(1) == 0);
            m_r_valid_i = 1'b1;
            r_q.push_back({m_r_last_i, m_r_payload_i});
        end
        m_aw_ready_i = ($urandom_range(99) < p_mready);
        m_ar_ready_i = ($urandom_range(99) < p_mready);
        m_w_ready_i  = ($urandom_range(99) < p_mready);
        s_b_ready_i  = ($urandom_range(99) < p_sready);
        s_r_ready_i  = ($urandom_range(99) < p_sready);
        #1;
        aw_ok = (mode == 0 && wr_out < MAXO && w_owe < MAXO) || aw_shown;
        ar_ok = (mode == 0 && rd_out < MAXO) || ar_shown;
        aw_hs = s_aw_valid_i && m_aw_ready_i && aw_ok;
        ar_hs = s_ar_valid_i && m_ar_ready_i && ar_ok;
        w_ok  = (w_owe > 0) || aw_hs;
        w_last_hs = s_w_valid_i && m_w_ready_i && w_ok && s_w_last_i;
        b_hs      = m_b_valid_i && s_b_ready_i;
        r_last_hs = m_r_valid_i && s_r_ready_i && m_r_last_i;
        exp_gate = {s_aw_valid_i && aw_ok, m_aw_ready_i && aw_ok,
                    s_ar_valid_i && ar_ok, m_ar_ready_i && ar_ok,
                    s_w_valid_i && w_ok,   m_w_ready_i && w_ok,
                    m_b_valid_i, s_b_ready_i, m_r_valid_i, s_r_ready_i};
        act_gate = {m_aw_valid_o, s_aw_ready_o, m_ar_valid_o, s_ar_ready_o,
                    m_w_valid_o, s_w_ready_o, s_b_valid_o, m_b_ready_o, s_r_valid_o, m_r_ready_o};
        chk("gating", 128'(act_gate), 128'(exp_gate));
        chk("isolate_ack", 128'(isolate_ack_o), 128'(mode == 2));
        chk("busy", 128'(busy_o), 128'(wr_out != 0 || rd_out != 0 || w_owe != 0));
        aw_done = s_aw_valid_i && s_aw_ready_o;
        ar_done = s_ar_valid_i && s_ar_ready_o;
        w_done  = s_w_valid_i && s_w_ready_o;
        b_done  = m_b_valid_i && m_b_ready_o;
        r_done  = m_r_valid_i && m_r_ready_o;
        quiet = (wr_out == 0 && rd_out == 0 && w_owe == 0 && !aw_shown && !ar_shown
                 && !aw_hs && !ar_hs);
        if (mode == 0 && req_want) mode = 1;
        else if (mode == 1 && !req_want) mode = 0;
        else if (mode == 1 && quiet) mode = 2;
        else if (mode == 2 && !req_want) mode = 0;
        wr_out = wr_out + int'(aw_hs) - int'(b_hs);
        rd_out = rd_out + int'(ar_hs) - int'(r_last_hs);
        w_owe  = w_owe + int'(aw_hs) - int'(w_last_hs);
        if (wr_out < 0) wr_out = 0;
        if (rd_out < 0) rd_out = 0;
        if (w_owe < 0)  w_owe = 0;
        aw_shown = aw_hs ? 1'b0 : ((s_aw_valid_i && aw_ok) ? 1'b1 : aw_shown);
        ar_shown = ar_hs ? 1'b0 : ((s_ar_valid_i && ar_ok) ? 1'b1 : ar_shown);
    endtask

    // Monitor: every transfer leaving the DUT must match the oldest pending scoreboard entry.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (m_aw_valid_o && m_aw_ready_i) begin
                if (aw_q.size() == 0) underflow("aw_payload");
                else chk("aw_payload", 128'(m_aw_payload_o), 128'(aw_q.pop_front()));
            end
            if (m_ar_valid_o && m_ar_ready_i) begin
                if (ar_q.size() == 0) underflow("ar_payload");
                else chk("ar_payload", 128'(m_ar_payload_o), 128'(ar_q.pop_front()));
            end
            if (m_w_valid_o && m_w_ready_i) begin
                if (w_q.size() == 0) underflow("w_payload");
                else chk("w_payload", 128'({m_w_last_o, m_w_payload_o}), 128'(w_q.pop_front()));
            end
            if (s_b_valid_o && s_b_ready_i) begin
                if (b_q.size() == 0) underflow("b_payload");
                else chk("b_payload", 128'(s_b_payload_o), 128'(b_q.pop_front()));
            end
            if (s_r_valid_o && s_r_ready_i) begin
                if (r_q.size() == 0) underflow("r_payload");
                else chk("r_payload", 128'({s_r_last_o, s_r_payload_o}), 128'(r_q.pop_front()));
            end
        end
    end

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        s_aw_valid_i = 1'b0; s_ar_valid_i = 1'b0; s_w_valid_i = 1'b0;
        m_b_valid_i = 1'b0; m_r_valid_i = 1'b0; isolate_req_i = 1'b0; req_want = 1'b0;
        aw_done = 1'b0; ar_done = 1'b0; w_done = 1'b0; b_done = 1'b0; r_done = 1'b0;
        aw_q.delete(); ar_q.delete(); w_q.delete(); b_q.delete(); r_q.delete();
        model_reset();
        repeat (cycles) @(negedge clk);
        #1;
        chk("rst_ack", 128'(isolate_ack_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_addr_valid", 128'({m_aw_valid_o, m_ar_valid_o, m_w_valid_o}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic knobs(input int aw, input int ar, input int w, input int rsp,
                         input int mr, input int sr);
        p_aw = aw; p_ar = ar; p_w = w; p_rsp = rsp; p_mready = mr; p_sready = sr;
    endtask

    initial begin
        rst_n = 1'b0; isolate_req_i = 1'b0;
        s_aw_payload_i = '0; s_ar_payload_i = '0; s_w_payload_i = '0; s_w_last_i = 1'b0;
        m_b_payload_i = '0; m_r_payload_i = '0; m_r_last_i = 1'b0;
        m_aw_ready_i = 1'b0; m_ar_ready_i = 1'b0; m_w_ready_i = 1'b0;
        s_b_ready_i = 1'b0; s_r_ready_i = 1'b0;
        do_reset(3);

        // Idle isolation, then release.
        knobs(0, 0, 0, 0, 100, 100);
        req_want = 1'b1;
        repeat (4) step();
        req_want = 1'b0;
        repeat (3) step();

        // Read saturation at the outstanding limit, then release with responses.
        knobs(0, 100, 0, 0, 100, 100);
        repeat (24) step();
        knobs(0, 100, 0, 100, 100, 100);
        repeat (12) step();

        // Mixed random traffic with isolation requests toggling.
        knobs(50, 50, 60, 40, 70, 70);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(49) == 0) req_want = !req_want;
            step();
        end

        // Hold isolation under traffic until fully drained.
        req_want = 1'b1;
        knobs(60, 60, 60, 50, 70, 70);
        begin
            int k;
            for (k = 0; k < 600 && mode != 2; k++) step();
            if (mode != 2)
                $display("FAIL drain_timeout got=mode%0d want=isolated within 600 cycles", mode);
            if (mode != 2) n_err++;
            step();
            chk("drain_ack", 128'(isolate_ack_o), 128'(1));
        end
        req_want = 1'b0;
        repeat (200) step();

        // Reset in the middle of traffic clears everything.
        do_reset(2);
        knobs(50, 50, 60, 40, 70, 70);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(39) == 0) req_want = !req_want;
            step();
        end

        // Anything still queued must correspond to a transfer still being presented.
        @(negedge clk);
        if (aw_done) s_aw_valid_i = 1'b0;
        if (ar_done) s_ar_valid_i = 1'b0;
        if (w_done)  s_w_valid_i  = 1'b0;
        if (b_done)  m_b_valid_i  = 1'b0;
        if (r_done)  m_r_valid_i  = 1'b0;
        #3;
        chk("aw_left", 128'(aw_q.size()), 128'(s_aw_valid_i));
        chk("ar_left", 128'(ar_q.size()), 128'(s_ar_valid_i));
        chk("w_left",  128'(w_q.size()),  128'(s_w_valid_i));
        chk("b_left",  128'(b_q.size()),  128'(m_b_valid_i));
        chk("r_left",  128'(r_q.size()),  128'(m_r_valid_i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
